// File: rtl/casca_pwm_multi.sv
// casca_pwm_multi: multi-channel PWM shell with switch-gated LEDs and all-off detection.
// Every switch input is synchronised, and all switch-dependent logic uses the synchronised copy.
// Optional feature: define CASCA_FADE_EN to move each level one step per FADE_PERIODS periods.
// Without CASCA_FADE_EN, each level jumps straight to its target at the next period boundary.
module casca_pwm_multi #(
  parameter int N_CH         = 3,
  parameter int N_LED        = 4,
  parameter int PWM_BITS     = 8,
  parameter int FADE_PERIODS = 4
) (
  input  logic                                   clk_50MHz,
  input  logic                                   rst_casca,
  input  logic [N_CH-1:0]                        sw_ch,
  input  logic [N_LED-1:0]                       sw_led,
  input  logic                                   sw_aux,
  input  logic                                   wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [PWM_BITS-1:0]                    wr_duty,
  output logic [N_CH-1:0]                        pwm_casca,
  output logic [N_LED-1:0]                       led,
  output logic                                   all_off,
  output logic                                   busy
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  // The counter runs 0 .. 2^PWM_BITS-2, so full scale (all ones) is never reached and gives constant high.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {ST_OFF, ST_UP, ST_DOWN, ST_HOLD} ch_state_t;

  logic [N_CH-1:0]     r_ch_s1, r_ch_s2;
  logic [N_LED-1:0]    r_led_s1, r_led_s2;
  logic                r_aux_s1, r_aux_s2;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_level  [N_CH];
  logic [PWM_BITS-1:0] r_target [N_CH];
  logic [N_CH-1:0]     r_pwm;
  logic [N_LED-1:0]    r_led;
  logic                r_all_off;
  logic                r_busy;

  logic [PWM_BITS-1:0] w_eff       [N_CH];
  logic [PWM_BITS-1:0] w_level_nxt [N_CH];
  ch_state_t           w_state     [N_CH];
  logic                w_bnd;
  logic                w_step;
  logic                w_any_sw;
  logic                w_busy_nxt;

  // One unit toward the effective target; the comparisons keep it from overshooting or wrapping.
  function automatic logic [PWM_BITS-1:0] f_step_toward(input logic [PWM_BITS-1:0] lvl,
                                                        input logic [PWM_BITS-1:0] eff);
    if (lvl < eff)      f_step_toward = lvl + 1'b1;
    else if (lvl > eff) f_step_toward = lvl - 1'b1;
    else                f_step_toward = lvl;
  endfunction

  assign w_bnd    = (r_cnt == CNT_LAST);
  assign w_any_sw = (|r_ch_s2) | (|r_led_s2) | r_aux_s2;

`ifdef CASCA_FADE_EN
  localparam int PW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  logic [PW-1:0] r_pre;

  // Shared fade prescaler: counts period boundaries and is held clear while everything is off.
  always_ff @(posedge clk_50MHz) begin
    if (rst_casca || r_all_off) r_pre <= '0;
    else if (w_bnd)             r_pre <= (r_pre == PW'(FADE_PERIODS - 1)) ? '0 : r_pre + 1'b1;
  end

  assign w_step = w_bnd && (r_pre == PW'(FADE_PERIODS - 1));
`else
  assign w_step = w_bnd;
`endif

  // Per-channel effective target and state, re-derived every cycle from level and eff.
  always_comb begin
    w_busy_nxt = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_eff[i] = (r_ch_s2[i] && !r_all_off) ? r_target[i] : '0;
      if (r_level[i] < w_eff[i])      w_state[i] = ST_UP;
      else if (r_level[i] > w_eff[i]) w_state[i] = ST_DOWN;
      else if (r_level[i] == '0)      w_state[i] = ST_OFF;
      else                            w_state[i] = ST_HOLD;
      if (w_state[i] == ST_UP || w_state[i] == ST_DOWN) w_busy_nxt = 1'b1;
    end
  end

  // Next level: forced to zero while all-off, otherwise updated only on a step boundary.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_level_nxt[i] = r_level[i];
      if (r_all_off) begin
        w_level_nxt[i] = '0;
      end else if (w_step) begin
`ifdef CASCA_FADE_EN
        w_level_nxt[i] = f_step_toward(r_level[i], w_eff[i]);
`else
        w_level_nxt[i] = w_eff[i];
`endif
      end
    end
  end

  // Synchronisers, period counter, levels, targets and registered outputs.
  always_ff @(posedge clk_50MHz) begin
    if (rst_casca) begin
      r_ch_s1   <= '0;
      r_ch_s2   <= '0;
      r_led_s1  <= '0;
      r_led_s2  <= '0;
      r_aux_s1  <= 1'b0;
      r_aux_s2  <= 1'b0;
      r_cnt     <= '0;
      r_pwm     <= '0;
      r_led     <= '0;
      r_all_off <= 1'b1;
      r_busy    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_level[i]  <= '0;
        r_target[i] <= '0;
      end
    end else begin
      r_ch_s1   <= sw_ch;
      r_ch_s2   <= r_ch_s1;
      r_led_s1  <= sw_led;
      r_led_s2  <= r_led_s1;
      r_aux_s1  <= sw_aux;
      r_aux_s2  <= r_aux_s1;
      r_cnt     <= w_bnd ? '0 : r_cnt + 1'b1;
      r_all_off <= !w_any_sw;
      r_busy    <= w_busy_nxt;
      r_led     <= r_led_s2 & {N_LED{!r_all_off}};
      for (int i = 0; i < N_CH; i++) begin
        r_level[i] <= w_level_nxt[i];
        r_pwm[i]   <= !r_all_off && (r_level[i] > r_cnt);
        // Indices at or above N_CH never match, so such writes fall away.
        if (wr_en && (wr_ch == CHW'(i))) r_target[i] <= wr_duty;
      end
    end
  end

  assign pwm_casca = r_pwm;
  assign led       = r_led;
  assign all_off   = r_all_off;
  assign busy      = r_busy;

endmodule

// File: tb/tb_casca_pwm_multi.sv
// Testbench for casca_pwm_multi (N_CH=3, N_LED=4, PWM_BITS=8, FADE_PERIODS=4).
// A cycle-level reference model predicts every output; directed tables and sequences add
// duty-cycle counts and the all-off / reset corner cases.
module tb_casca_pwm_multi;

  localparam int NC  = 3;
  localparam int NL  = 4;
  localparam int PB  = 8;
  localparam int FP  = 4;
  localparam int PER = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] sw_ch = '0;
  logic [NL-1:0] sw_led = '0;
  logic          sw_aux = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [PB-1:0] wr_duty = '0;
  logic [NC-1:0] pwm_casca;
  logic [NL-1:0] led;
  logic          all_off;
  logic          busy;

  int n_pass = 0;
  int n_total = 0;

  casca_pwm_multi #(.N_CH(NC), .N_LED(NL), .PWM_BITS(PB), .FADE_PERIODS(FP)) dut (
    .clk_50MHz(clk), .rst_casca(rst), .sw_ch(sw_ch), .sw_led(sw_led), .sw_aux(sw_aux),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_casca(pwm_casca), .led(led), .all_off(all_off), .busy(busy));

  always #10 clk = ~clk;

  // Reference model state
  int          m_level [NC];
  int          m_target[NC];
  int          m_cyc;
  int          m_bcnt;
  bit          m_all_off = 1'b1;
  bit [NC-1:0] m_pwm = '0;
  bit [NL-1:0] m_led = '0;
  bit          m_busy = 1'b0;
  bit [NC-1:0] m_ch1, m_ch2;
  bit [NL-1:0] m_led1, m_led2;
  bit          m_aux1, m_aux2;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Advance the model across one clock edge using the values present before the edge.
  task automatic model_edge();
    int eff[NC];
    int cntp;
    bit bnd, step;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin m_level[i] = 0; m_target[i] = 0; end
      m_cyc = 0; m_bcnt = 0; m_all_off = 1; m_pwm = '0; m_led = '0; m_busy = 0;
      m_ch1 = '0; m_ch2 = '0; m_led1 = '0; m_led2 = '0; m_aux1 = 0; m_aux2 = 0;
      return;
    end
    cntp = m_cyc % PER;
    bnd  = (cntp == PER - 1);
`ifdef CASCA_FADE_EN
    step = bnd && ((m_bcnt % FP) == FP - 1);
`else
    step = bnd;
`endif
    m_busy = 0;
    for (int i = 0; i < NC; i++) begin
      eff[i] = (m_ch2[i] && !m_all_off) ? m_target[i] : 0;
      if (m_level[i] != eff[i]) m_busy = 1;
      m_pwm[i] = !m_all_off && (m_level[i] > cntp);
    end
    m_led = m_all_off ? '0 : m_led2;
    for (int i = 0; i < NC; i++) begin
      if (m_all_off) m_level[i] = 0;
      else if (step) begin
`ifdef CASCA_FADE_EN
        if (eff[i] > m_level[i]) m_level[i]++;
        else if (eff[i] < m_level[i]) m_level[i]--;
`else
        m_level[i] = eff[i];
`endif
      end
    end
    if (m_all_off) m_bcnt = 0;
    else if (bnd) m_bcnt++;
    if (wr_en && int'(wr_ch) < NC) m_target[wr_ch] = int'(wr_duty);
    m_all_off = !((|m_ch2) || (|m_led2) || m_aux2);
    m_ch2 = m_ch1; m_ch1 = sw_ch;
    m_led2 = m_led1; m_led1 = sw_led;
    m_aux2 = m_aux1; m_aux1 = sw_aux;
    m_cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    n_total++;
    if ({pwm_casca, led, all_off, busy} === {m_pwm, m_led, m_all_off, m_busy}) n_pass++;
    else $display("FAIL model: got pwm=%b led=%b all_off=%b busy=%b expected pwm=%b led=%b all_off=%b busy=%b (t=%0t)",
                  pwm_casca, led, all_off, busy, m_pwm, m_led, m_all_off, m_busy, $time);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; ticks(2); rst = 1'b0;
  endtask

  task automatic write(input int ch, input int duty);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = PB'(duty);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic count_high(input int ch, input int periods, output int n);
    n = 0;
    for (int k = 0; k < periods * PER; k++) begin
      tick();
      n += int'(pwm_casca[ch]);
    end
  endtask

  // Run the model clock up to a given number of edges since reset release.
  task automatic tick_until(input int cyc);
    for (int k = 0; k < 20000 && m_cyc < cyc; k++) tick();
  endtask

  typedef struct {
    int          ch;
    int          duty;
    logic [NC-1:0] sw;
    int          exp;
  } vec_t;

  vec_t vecs[$];
  int   n, settle, k_on, tgt;

  initial begin
`ifdef CASCA_FADE_EN
    vecs.push_back('{0, 2, 3'b001, 2});
    vecs.push_back('{2, 0, 3'b100, 0});
    vecs.push_back('{1, 3, 3'b010, 3});
    vecs.push_back('{1, 3, 3'b001, 0});
    vecs.push_back('{2, 1, 3'b100, 1});
    tgt = 5;
`else
    vecs.push_back('{0, 128, 3'b001, 128});
    vecs.push_back('{2,   0, 3'b100,   0});
    vecs.push_back('{2, 255, 3'b100, 255});
    vecs.push_back('{1,  77, 3'b010,  77});
    vecs.push_back('{1, 200, 3'b001,   0});
    vecs.push_back('{0,   1, 3'b001,   1});
    vecs.push_back('{2, 254, 3'b111, 254});
    tgt = 200;
`endif

    // Reset state
    do_reset();
    check("reset_all_off", int'(all_off), 1);
    check("reset_pwm", int'(pwm_casca), 0);
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);

    // Table: steady-state duty measured over three periods
    foreach (vecs[v]) begin
      do_reset();
      sw_ch = vecs[v].sw; sw_led = '0; sw_aux = 1'b0;
      write(vecs[v].ch, vecs[v].duty);
`ifdef CASCA_FADE_EN
      settle = vecs[v].duty * FP + 3;
`else
      settle = 3;
`endif
      ticks(settle * PER);
      count_high(vecs[v].ch, 3, n);
      check($sformatf("duty_vec%0d", v), n, vecs[v].exp * 3);
    end

`ifdef CASCA_FADE_EN
    // Fade ramp 0 -> 1 -> 2 -> 3 at boundaries 4, 8, 12
    do_reset();
    sw_ch = 3'b010;
    write(1, 3);
    tick_until(4 * PER);
    count_high(1, 1, n);
    check("fade_lvl1", n, 1);
    check("fade_busy", int'(busy), 1);
    tick_until(8 * PER);
    count_high(1, 1, n);
    check("fade_lvl2", n, 2);
    tick_until(12 * PER);
    count_high(1, 1, n);
    check("fade_lvl3", n, 3);
    check("fade_busy_done", int'(busy), 0);
`endif

    // All-off: drop every switch with ch0 at its target, then bring ch0 back
    do_reset();
    sw_ch = 3'b001; sw_led = 4'b1010;
    write(0, tgt);
`ifdef CASCA_FADE_EN
    ticks((tgt * FP + 3) * PER);
`else
    ticks(3 * PER);
`endif
    count_high(0, 1, n);
    check("alloff_pre_level", n, tgt);
    check("alloff_pre_led", int'(led), 4'b1010);
    sw_ch = '0; sw_led = '0; sw_aux = 1'b0;
    k_on = 0;
    for (int k = 1; k <= 6 && k_on == 0; k++) begin
      tick();
      if (all_off) k_on = k;
    end
    check("alloff_rise_ok", int'(k_on >= 2 && k_on <= 3), 1);
    tick();
    check("alloff_pwm", int'(pwm_casca), 0);
    check("alloff_led", int'(led), 0);
    ticks(2 * PER);
    sw_ch = 3'b001;
`ifdef CASCA_FADE_EN
    ticks((tgt * FP + 3) * PER);
`else
    ticks(3 * PER);
`endif
    count_high(0, 1, n);
    check("alloff_recover", n, tgt);

    // Out-of-range channel write is ignored
    write(3, 17);
    ticks(2 * PER);
    count_high(0, 1, n);
    check("wr_ch3_ignored", n, tgt);

    // Reset pulse in the middle of a change
    write(0, tgt / 2);
    ticks(PER + 100);
    rst = 1'b1;
    tick();
    check("midreset_pwm", int'(pwm_casca), 0);
    check("midreset_led", int'(led), 0);
    check("midreset_all_off", int'(all_off), 1);
    check("midreset_busy", int'(busy), 0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      if (c % 64 == 0) begin
        if ($urandom_range(0, 9) < 3) begin
          sw_ch = '0; sw_led = '0; sw_aux = 1'b0;
        end else begin
          sw_ch = NC'($urandom); sw_led = NL'($urandom); sw_aux = 1'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        wr_en = 1'b1;
        wr_ch = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0:       wr_duty = '0;
          1:       wr_duty = '1;
          default: wr_duty = PB'($urandom);
        endcase
      end else begin
        wr_en = 1'b0;
      end
      rst = (c == 12345);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
